pipe_chain_param: RTL

- Parametrised successor to the two-flop launch/capture cell: a DEPTH-stage, WIDTH-bit registered datapath with valid/ready flow control.
- Stage 0 applies a selectable transform; later stages forward data unchanged.
- Used as the configurable launch/capture chain for timing experiments. The ready chain is deliberately combinational across all stages, giving a long reg-to-reg path scaled by DEPTH.

---
 rtl/pipe_chain_param.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pipe_chain_param.sv
// DEPTH-stage, WIDTH-bit registered chain with valid/ready flow control and a stage-0 transform.
// Optional per-stage parity tracking is enabled by defining PIPE_CHAIN_PARITY_EN.
module pipe_chain_param #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk_net,
    input  logic                       reset_net,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [1:0]                 mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           acc_count,
    input  logic                       par_inj,
    output logic                       par_err
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] ready;
    logic [WIDTH-1:0] xform;
    logic             in_fire;
    logic             out_fire;
    logic [OCC_W-1:0] occ_q;
    logic [CNT_W-1:0] acc_q;

    function automatic logic [WIDTH-1:0] transform(input logic [WIDTH-1:0] d,
                                                   input logic [1:0]       m);
        logic [WIDTH-1:0] r;
        case (m)
            2'b00:   r = d;
            2'b01:   r = ~d;
            2'b10:   r = d ^ (d >> 1);
            default: r = {d[WIDTH-2:0], d[WIDTH-1]};
        endcase
        return r;
    endfunction

    assign xform = transform(in_data, mode);

    // Ready ripples combinationally from out_ready back to stage 0; this long path is intentional.
    always_comb begin : ready_chain
        logic r;
        ready = '0;
        r     = out_ready;
        for (int k = DEPTH-1; k >= 0; k--) begin
            r        = ~valid_q[k] | r;
            ready[k] = r;
        end
    end

    assign in_ready  = ready[0];
    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign in_fire   = in_valid & ready[0];
    assign out_fire  = valid_q[DEPTH-1] & out_ready;
    assign occupancy = occ_q;
    assign acc_count = acc_q;

    always_ff @(posedge clk_net or negedge reset_net) begin
        if (!reset_net) begin
            valid_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            if (ready[0]) begin
                valid_q[0] <= in_valid;
                data_q[0]  <= xform;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (ready[k]) begin
                    valid_q[k] <= valid_q[k-1];
                    data_q[k]  <= data_q[k-1];
                end
            end
        end
    end

    // Occupancy tracks entries in flight; a simultaneous accept and drain leaves it unchanged.
    always_ff @(posedge clk_net or negedge reset_net) begin
        if (!reset_net) begin
            occ_q <= '0;
            acc_q <= '0;
        end else begin
            case ({in_fire, out_fire})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
            if (in_fire) begin
                acc_q <= acc_q + CNT_W'(1);
            end
        end
    end

`ifdef PIPE_CHAIN_PARITY_EN
    logic [DEPTH-1:0] par_q;
    logic             par_err_q;

    always_ff @(posedge clk_net or negedge reset_net) begin
        if (!reset_net) begin
            par_q     <= '0;
            par_err_q <= 1'b0;
        end else begin
            if (ready[0]) begin
                par_q[0] <= (^xform) ^ par_inj;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (ready[k]) begin
                    par_q[k] <= par_q[k-1];
                end
            end
            if (out_fire && ((^data_q[DEPTH-1]) != par_q[DEPTH-1])) begin
                par_err_q <= 1'b1;
            end
        end
    end

    assign par_err = par_err_q;
`else
    logic unused_par_inj;

    assign unused_par_inj = par_inj;
    assign par_err        = 1'b0;
`endif

endmodule
